// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update controller.
package bp_pkg;

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } bp_state_e;

    localparam logic [31:0] PC_STEP            = 32'd4;
    localparam int          DEFAULT_ENTRY_BITS = 4;

    typedef struct packed {
        logic        valid;
        logic        pred;
        logic [31:0] ptgt;
        logic [31:0] pc;
    } bp_stage_t;

endpackage

// File: rtl/bp_track_stage.sv
// One pipeline tracking register (D or E) for predictor metadata: hold, flush or load.
module bp_track_stage
    import bp_pkg::*;
(
    input  logic      clk,
    input  logic      reset_i,
    input  logic      hold_i,
    input  logic      flush_i,
    input  bp_stage_t load_i,
    output bp_stage_t stage_o
);

    bp_stage_t stage_q;

    // Flush beats hold so a misprediction always kills wrong-path entries.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            stage_q <= '0;
        end else if (flush_i) begin
            stage_q.valid <= 1'b0;
        end else if (!hold_i) begin
            stage_q <= load_i;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch predictor update/recovery controller with a NORMAL/RECOVER FSM.
// Optional statistics counters (BrCount, MissCount) enabled by macro BP_STATS_EN.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int ENTRY_BITS = DEFAULT_ENTRY_BITS
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic [31:0]           PC_F,
    input  logic                  PrPCSrc_F,
    input  logic [31:0]           PrALUResult_F,
    input  logic                  Stall,
    input  logic                  Branch_E,
    input  logic                  PCSrc_E,
    input  logic [31:0]           ALUResult_E,
    output logic [ENTRY_BITS-1:0] PC_E,
    output logic                  WE_PrPCSrc,
    output logic                  WE_PrALUResult,
    output logic                  Flush_BP,
    output logic                  Redirect_Valid,
    output logic [31:0]           Redirect_PC
`ifdef BP_STATS_EN
    ,
    output logic [31:0]           BrCount,
    output logic [31:0]           MissCount
`endif
);

    bp_stage_t dStage;
    bp_stage_t eStage;
    bp_stage_t fetchLoad;
    bp_state_e state_q;

    logic act;
    logic actual;
    logic dirMiss;
    logic tgtMiss;
    logic miss;

    assign fetchLoad = '{valid: 1'b1, pred: PrPCSrc_F, ptgt: PrALUResult_F, pc: PC_F};

    bp_track_stage uStageD (
        .clk     (clk),
        .reset_i (RESET),
        .hold_i  (Stall),
        .flush_i (miss),
        .load_i  (fetchLoad),
        .stage_o (dStage)
    );

    bp_track_stage uStageE (
        .clk     (clk),
        .reset_i (RESET),
        .hold_i  (Stall),
        .flush_i (miss),
        .load_i  (dStage),
        .stage_o (eStage)
    );

    // Resolution is gated by RESET so a reset cycle never writes the predictor.
    assign act     = eStage.valid & (Branch_E | eStage.pred) & ~Stall
                   & (state_q == NORMAL) & ~RESET;
    assign actual  = Branch_E & PCSrc_E;
    assign dirMiss = eStage.pred != actual;
    assign tgtMiss = eStage.pred & actual & (eStage.ptgt != ALUResult_E);
    assign miss    = act & (dirMiss | tgtMiss);

    assign PC_E           = eStage.pc[ENTRY_BITS+1:2];
    assign WE_PrPCSrc     = act;
    assign WE_PrALUResult = act & actual & (~eStage.pred | tgtMiss);
    assign Flush_BP       = miss;
    assign Redirect_Valid = miss;
    assign Redirect_PC    = !miss ? 32'd0
                          : (actual ? ALUResult_E : eStage.pc + PC_STEP);

    // RECOVER lasts exactly one cycle, covering the bubble left by the flush.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= NORMAL;
        end else begin
            case (state_q)
                NORMAL:  state_q <= miss ? RECOVER : NORMAL;
                RECOVER: state_q <= NORMAL;
                default: state_q <= NORMAL;
            endcase
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] brCount_q;
    logic [31:0] missCount_q;

    always_ff @(posedge clk) begin
        if (RESET) begin
            brCount_q   <= '0;
            missCount_q <= '0;
        end else begin
            if (act && Branch_E && brCount_q != 32'hFFFF_FFFF) begin
                brCount_q <= brCount_q + 32'd1;
            end
            if (miss && missCount_q != 32'hFFFF_FFFF) begin
                missCount_q <= missCount_q + 32'd1;
            end
        end
    end

    assign BrCount   = brCount_q;
    assign MissCount = missCount_q;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl; define BP_STATS_EN to also exercise the counters.
module tb_bp_update_ctrl;

    logic        clk;
    logic        RESET;
    logic [31:0] PC_F;
    logic        PrPCSrc_F;
    logic [31:0] PrALUResult_F;
    logic        Stall;
    logic        Branch_E;
    logic        PCSrc_E;
    logic [31:0] ALUResult_E;
    logic [3:0]  PC_E;
    logic        WE_PrPCSrc;
    logic        WE_PrALUResult;
    logic        Flush_BP;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
`ifdef BP_STATS_EN
    logic [31:0] BrCount;
    logic [31:0] MissCount;
`endif

    bp_update_ctrl #(.ENTRY_BITS(4)) dut (
        .clk            (clk),
        .RESET          (RESET),
        .PC_F           (PC_F),
        .PrPCSrc_F      (PrPCSrc_F),
        .PrALUResult_F  (PrALUResult_F),
        .Stall          (Stall),
        .Branch_E       (Branch_E),
        .PCSrc_E        (PCSrc_E),
        .ALUResult_E    (ALUResult_E),
        .PC_E           (PC_E),
        .WE_PrPCSrc     (WE_PrPCSrc),
        .WE_PrALUResult (WE_PrALUResult),
        .Flush_BP       (Flush_BP),
        .Redirect_Valid (Redirect_Valid),
        .Redirect_PC    (Redirect_PC)
`ifdef BP_STATS_EN
        ,
        .BrCount        (BrCount),
        .MissCount      (MissCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] ptgt;
        logic        br;
        logic        src;
        logic [31:0] alu;
        logic        weSrc;
        logic        weTgt;
        logic        flush;
        logic [31:0] rpc;
        logic [3:0]  pce;
    } vec_t;

    typedef struct {
        logic        weSrc;
        logic        weTgt;
        logic        flush;
        logic [31:0] rpc;
        logic [3:0]  pce;
    } exp_t;

    vec_t vecs[9];
    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] actVal, input logic [31:0] expVal);
        checks++;
        if (actVal !== expVal) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actVal, expVal);
        end
    endtask

    task automatic resetDut();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic driveE(input vec_t v);
        Branch_E    = v.br;
        PCSrc_E     = v.src;
        ALUResult_E = v.alu;
    endtask

    task automatic applyStimulus(input vec_t v);
        driveE(v);
        expQ.push_back('{weSrc: v.weSrc, weTgt: v.weTgt, flush: v.flush, rpc: v.rpc, pce: v.pce});
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got nothing expected", tag);
        end else begin
            e = expQ.pop_front();
            checkVal({tag, "_weSrc"}, WE_PrPCSrc, e.weSrc);
            checkVal({tag, "_weTgt"}, WE_PrALUResult, e.weTgt);
            checkVal({tag, "_flush"}, Flush_BP, e.flush);
            checkVal({tag, "_rvalid"}, Redirect_Valid, e.flush);
            checkVal({tag, "_rpc"}, Redirect_PC, e.rpc);
            checkVal({tag, "_pce"}, PC_E, e.pce);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkVal({tag, "_weSrc"}, WE_PrPCSrc, 0);
        checkVal({tag, "_weTgt"}, WE_PrALUResult, 0);
        checkVal({tag, "_flush"}, Flush_BP, 0);
        checkVal({tag, "_rvalid"}, Redirect_Valid, 0);
        checkVal({tag, "_rpc"}, Redirect_PC, 0);
    endtask

    // Walk one instruction F->D->E with harmless filler behind it, then check resolution and aftermath.
    task automatic runVector(input vec_t v, input bit doReset, input string tag);
        if (doReset) resetDut();
        PC_F = v.pc; PrPCSrc_F = v.pred; PrALUResult_F = v.ptgt;
        tick();
        PC_F = 32'd0; PrPCSrc_F = 1'b0; PrALUResult_F = 32'd0;
        tick();
        applyStimulus(v);
        #1;
        checkOutput(tag);
        tick();
        Branch_E = 1'b0; PCSrc_E = 1'b0; ALUResult_E = 32'd0;
        #1;
        checkVal({tag, "_recover"}, dut.state_q, v.flush);
        checkVal({tag, "_eValid"}, dut.eStage.valid, !v.flush);
        tick();
    endtask

    initial begin
        RESET = 1'b0; PC_F = '0; PrPCSrc_F = 1'b0; PrALUResult_F = '0;
        Stall = 1'b0; Branch_E = 1'b0; PCSrc_E = 1'b0; ALUResult_E = '0;

        //            pc            pred ptgt          br   src  alu           weS  weT  fl   rpc           pce
        vecs[0] = '{32'h0000_0010, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'h4};
        vecs[1] = '{32'h0000_0020, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 4'h8};
        vecs[2] = '{32'h0000_0050, 1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0044, 1'b1, 1'b1, 1'b1, 32'h0000_0044, 4'h4};
        vecs[3] = '{32'h0000_0030, 1'b1, 32'h0000_0060, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0034, 4'hC};
        vecs[4] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 4'hF};
        vecs[5] = '{32'h0000_0008, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'h2};
        vecs[6] = '{32'h0000_0014, 1'b1, 32'h0000_0090, 1'b1, 1'b0, 32'h0000_0090, 1'b1, 1'b0, 1'b1, 32'h0000_0018, 4'h5};
        vecs[7] = '{32'h0000_003C, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'hF};
        vecs[8] = '{32'h0000_0024, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0070, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h9};

        // Reset state: E is a bubble, so even an asserted branch must not update anything.
        resetDut();
        Branch_E = 1'b1; PCSrc_E = 1'b1; ALUResult_E = 32'h1234;
        #1;
        checkQuiet("reset_bubble");
        checkVal("reset_pce", PC_E, 0);
        checkVal("reset_state", dut.state_q, 0);
        Branch_E = 1'b0; PCSrc_E = 1'b0; ALUResult_E = '0;

        for (int i = 0; i < 9; i++) begin
            runVector(vecs[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Stall holds a pending misprediction until it drops, then exactly one pulse.
        resetDut();
        PC_F = vecs[1].pc; PrPCSrc_F = vecs[1].pred; PrALUResult_F = vecs[1].ptgt;
        tick();
        PC_F = '0; PrPCSrc_F = 1'b0; PrALUResult_F = '0;
        tick();
        Stall = 1'b1;
        driveE(vecs[1]);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkQuiet($sformatf("stall%0d", k));
            checkVal($sformatf("stall%0d_pce", k), PC_E, vecs[1].pce);
            tick();
        end
        Stall = 1'b0;
        applyStimulus(vecs[1]);
        #1;
        checkOutput("stall_release");
        tick();
        #1;
        checkQuiet("post_miss");
        checkVal("post_miss_state", dut.state_q, 1);
        checkVal("post_miss_dValid", dut.dStage.valid, 0);

        // Reset while in RECOVER aborts the recovery.
        RESET = 1'b1;
        #1;
        checkQuiet("reset_in_recover");
        tick();
        RESET = 1'b0;
        #1;
        checkVal("rst_recover_state", dut.state_q, 0);
        checkVal("rst_recover_dValid", dut.dStage.valid, 0);
        checkVal("rst_recover_eValid", dut.eStage.valid, 0);
        Branch_E = 1'b0; PCSrc_E = 1'b0; ALUResult_E = '0;

`ifdef BP_STATS_EN
        resetDut();
        checkVal("stats_reset_br", BrCount, 0);
        checkVal("stats_reset_miss", MissCount, 0);
        runVector(vecs[0], 1'b0, "stats0");
        runVector(vecs[5], 1'b0, "stats1");
        runVector(vecs[1], 1'b0, "stats2");
        runVector(vecs[2], 1'b0, "stats3");
        runVector(vecs[0], 1'b0, "stats4");
        checkVal("stats_br", BrCount, 5);
        checkVal("stats_miss", MissCount, 2);
        force dut.brCount_q = 32'hFFFF_FFFF;
        #1;
        release dut.brCount_q;
        runVector(vecs[0], 1'b0, "stats_sat");
        checkVal("stats_br_sat", BrCount, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_update_ctrl.md
BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_BITS, default 4, predictor index width (predictor holds 2**ENTRY_BITS entries).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port PC_F  input  32  fetch PC.
REQ-005 SHALL have port PrPCSrc_F  input  1  predictor taken flag for PC_F.
REQ-006 SHALL have port PrALUResult_F  input  32  predicted target for PC_F.
REQ-007 SHALL have port Stall  input  1  freeze D/E tracking.
REQ-008 SHALL have port Branch_E  input  1  instruction in E is a branch.
REQ-009 SHALL have port PCSrc_E  input  1  resolved branch taken.
REQ-010 SHALL have port ALUResult_E  input  32  resolved branch target.
REQ-011 SHALL have port PC_E  output  ENTRY_BITS  predictor update index, equal to tracked E PC bits [ENTRY_BITS+1:2].
REQ-012 SHALL have port WE_PrPCSrc  output  1  predictor counter write enable.
REQ-013 SHALL have port WE_PrALUResult  output  1  predictor target write enable.
REQ-014 SHALL have port Flush_BP  output  1  flush D and E stages.
REQ-015 SHALL have port Redirect_Valid  output  1  override fetch PC.
REQ-016 SHALL have port Redirect_PC  output  32  corrected next PC.
REQ-017 SHALL have ports BrCount and MissCount  output  32 each, only when BP_STATS_EN is defined.

Function
REQ-018 SHALL track per stage D and E: valid, pred, ptgt (32), pc (32); F->D captures PC_F/PrPCSrc_F/PrALUResult_F with valid=1; D->E copies D.
REQ-019 SHALL hold both stages unchanged while Stall=1 and Flush_BP=0.
REQ-020 SHALL define act = E.valid & (Branch_E | E.pred) & ~Stall & (state==NORMAL).
REQ-021 SHALL define actual = Branch_E & PCSrc_E; dir_miss = E.pred != actual; tgt_miss = E.pred & actual & (E.ptgt != ALUResult_E); miss = act & (dir_miss | tgt_miss).
REQ-022 SHALL drive WE_PrPCSrc = act (every resolved branch plus every false-taken non-branch), combinationally, zero-cycle latency from E inputs.
REQ-023 SHALL drive WE_PrALUResult = act & actual & (~E.pred | tgt_miss).
REQ-024 SHALL drive Flush_BP = Redirect_Valid = miss; Redirect_PC = actual ? ALUResult_E : E.pc + 32'd4 (modulo 2**32 wrap); Redirect_PC = 0 when miss=0.
REQ-025 SHALL on miss clear D.valid and E.valid at the next edge, regardless of Stall.
REQ-026 SHALL implement FSM NORMAL/RECOVER: NORMAL->RECOVER on miss; RECOVER->NORMAL unconditionally after one cycle; in RECOVER no update, flush or redirect is issued.
REQ-027 SHALL give Stall priority over a pending E-stage resolution: the resolution is evaluated in the first cycle with Stall=0.
REQ-028 SHALL ignore E when E.valid=0 (bubble): all write enables 0.

Reset
REQ-029 SHALL on RESET=1 at an edge clear all valid bits, pred, ptgt, pc, and counters to 0, and set state to NORMAL; outputs then read 0.
REQ-030 SHALL abort any in-flight recovery when RESET is asserted mid-operation, with no update issued in that cycle.

Configuration
REQ-031 SHALL, with macro BP_STATS_EN defined, increment BrCount on each act&Branch_E and MissCount on each miss, both saturating at 32'hFFFFFFFF.
REQ-032 SHALL, without BP_STATS_EN, omit both counter ports and their logic, with function otherwise identical.

Structure
REQ-033 SHALL place the state enum (NORMAL, RECOVER), PC_STEP=4 and the default ENTRY_BITS in shared package bp_pkg.
REQ-034 SHALL implement one tracking stage as sub-module bp_track_stage (hold, flush, load), instantiated twice (D, E).

Verification
REQ-035 SHALL test: correctly predicted taken branch (pred=1, ptgt=0x100, ALUResult_E=0x100, PCSrc_E=1) -> WE_PrPCSrc=1, WE_PrALUResult=0, Flush_BP=0.
REQ-036 SHALL test: branch at PC 0x20 predicted not-taken, resolves taken to 0x80 -> PC_E=4'h8, both WEs=1, Redirect_PC=0x80, next cycle RECOVER and D/E invalid.
REQ-037 SHALL test: target mismatch (ptgt=0x40, ALUResult_E=0x44, taken) -> miss, WE_PrALUResult=1, Redirect_PC=0x44.
REQ-038 SHALL test: non-branch at 0x30 with pred=1 -> WE_PrPCSrc=1, Redirect_PC=0x34; and PC 0xFFFFFFFC false-taken -> Redirect_PC=0x0.
REQ-039 SHALL test: miss condition with Stall=1 for 3 cycles -> no outputs until Stall drops, then exactly one miss pulse; RESET asserted in RECOVER -> state NORMAL, valids 0.
REQ-040 SHALL test (BP_STATS_EN): 5 branches with 2 misses -> BrCount=5, MissCount=2; counter preloaded to 0xFFFFFFFF stays saturated.
